// File: rtl/alu_operand_arbiter.sv
// alu_operand_arbiter: burst-bounded round-robin between two operand requesters feeding a one-entry ALU output register
module alu_operand_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    output logic             sel,
    output logic             y_valid,
    output logic [WIDTH-1:0] y_data,
    output logic             y_src,
    input  logic             y_ready
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
    localparam logic [3:0] MAX_B = 4'(MAX_BURST);
    state_t           state_q, state_d;
    logic [3:0]       burst_q, burst_d;
    logic             y_valid_q, y_valid_d, y_src_q, y_src_d;
    logic [WIDTH-1:0] y_data_q, y_data_d;
    logic             load_en, gnt_a, gnt_b, gnt, same, sat;
    always_comb begin
        load_en = !y_valid_q || y_ready;
        sat     = burst_q >= MAX_B;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        if (load_en) begin
            if (a_valid && b_valid) begin
                gnt_a = state_q == OWN_B ? sat : state_q == OWN_A ? !sat : 1'b1;
                gnt_b = !gnt_a;
            end else begin
                gnt_a = a_valid;
                gnt_b = b_valid;
            end
        end
        gnt       = gnt_a || gnt_b;
        same      = (gnt_a && state_q == OWN_A) || (gnt_b && state_q == OWN_B);
        // sel follows the grant; while stalled it parks on the last owner
        sel       = gnt_b || (!load_en && state_q == OWN_B);
        state_d   = !load_en ? state_q : gnt_a ? OWN_A : gnt_b ? OWN_B : IDLE;
        burst_d   = !load_en ? burst_q : !gnt ? 4'd0 : !same ? 4'd1 : sat ? MAX_B : burst_q + 4'd1;
        y_valid_d = load_en ? gnt : y_valid_q;
        y_data_d  = gnt ? (sel ? b_data : a_data) : y_data_q;
        y_src_d   = gnt ? gnt_b : y_src_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            burst_q   <= 4'd0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
            y_src_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            burst_q   <= burst_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
            y_src_q   <= y_src_d;
        end
    end
    assign a_ready = gnt_a;
    assign b_ready = gnt_b;
    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;
    assign y_src   = y_src_q;
endmodule

// File: tb/tb_alu_operand_arbiter.sv
// tb_alu_operand_arbiter: table-driven vectors plus directed stall, streaming, alternation and reset sequences
module tb_alu_operand_arbiter;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, y_ready;
    logic [7:0] a_data, b_data;
    logic       a_ready, b_ready, sel, y_valid, y_src;
    logic [7:0] y_data;
    logic       a_ready1, b_ready1, sel1, y_valid1, y_src1;
    logic [7:0] y_data1;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    alu_operand_arbiter #(.WIDTH(8), .MAX_BURST(4)) u0 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
        .sel(sel), .y_valid(y_valid), .y_data(y_data), .y_src(y_src), .y_ready(y_ready)
    );

    alu_operand_arbiter #(.WIDTH(8), .MAX_BURST(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready1),
        .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready1),
        .sel(sel1), .y_valid(y_valid1), .y_data(y_data1), .y_src(y_src1), .y_ready(y_ready)
    );

    typedef struct {
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       yr;
        logic       ar, br, sl, yv;
        logic [7:0] yd;
        logic       ys;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [7:0] ad, input logic bv, input logic [7:0] bd, input logic yr);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; y_ready = yr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0};
        tbl[2]  = '{1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0};
        tbl[3]  = '{1'b1, 8'h12, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
        tbl[4]  = '{1'b1, 8'h13, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0};
        tbl[5]  = '{1'b1, 8'h14, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 1'b0};
        tbl[6]  = '{1'b1, 8'h15, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h14, 1'b0};
        tbl[7]  = '{1'b1, 8'h15, 1'b1, 8'h23, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1};
        tbl[8]  = '{1'b1, 8'h15, 1'b1, 8'h24, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h23, 1'b1};
        tbl[9]  = '{1'b1, 8'h15, 1'b1, 8'h25, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h24, 1'b1};
        tbl[10] = '{1'b1, 8'h15, 1'b1, 8'h26, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h25, 1'b1};
        tbl[11] = '{1'b1, 8'h15, 1'b1, 8'h26, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h25, 1'b1};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h15, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("rst_y_valid", {7'd0, y_valid}, 8'd0);
        chk("rst_y_data", y_data, 8'h00);
        chk("rst_y_src", {7'd0, y_src}, 8'd0);
        chk("rst_a_ready", {7'd0, a_ready}, 8'd0);
        chk("rst_b_ready", {7'd0, b_ready}, 8'd0);
        chk("rst_sel", {7'd0, sel}, 8'd0);
        next_cycle();
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].yr);
            @(negedge clk);
            chk($sformatf("v%0d_a_ready", i), {7'd0, a_ready}, {7'd0, tbl[i].ar});
            chk($sformatf("v%0d_b_ready", i), {7'd0, b_ready}, {7'd0, tbl[i].br});
            chk($sformatf("v%0d_sel", i), {7'd0, sel}, {7'd0, tbl[i].sl});
            chk($sformatf("v%0d_y_valid", i), {7'd0, y_valid}, {7'd0, tbl[i].yv});
            chk($sformatf("v%0d_y_data", i), y_data, tbl[i].yd);
            chk($sformatf("v%0d_y_src", i), {7'd0, y_src}, {7'd0, tbl[i].ys});
            next_cycle();
        end

        drive(1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("stall_load_a_ready", {7'd0, a_ready}, 8'd1);
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h5B, 1'b0, 8'h00, 1'b0);
            @(negedge clk);
            chk($sformatf("stall%0d_y_valid", k), {7'd0, y_valid}, 8'd1);
            chk($sformatf("stall%0d_y_data", k), y_data, 8'h5A);
            chk($sformatf("stall%0d_a_ready", k), {7'd0, a_ready}, 8'd0);
            chk($sformatf("stall%0d_b_ready", k), {7'd0, b_ready}, 8'd0);
            next_cycle();
        end
        y_ready = 1'b1;
        @(negedge clk);
        chk("release_a_ready", {7'd0, a_ready}, 8'd1);
        chk("release_y_data", y_data, 8'h5A);
        next_cycle();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("after_stall_y_data", y_data, 8'h5B);
        chk("after_stall_y_valid", {7'd0, y_valid}, 8'd1);
        next_cycle();

        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 8'h00, 1'b1, 8'(i), 1'b1);
            @(negedge clk);
            chk($sformatf("bstream%0d_b_ready", i), {7'd0, b_ready}, 8'd1);
            chk($sformatf("bstream%0d_sel", i), {7'd0, sel}, 8'd1);
            if (i > 0) begin
                chk($sformatf("bstream%0d_y_data", i), y_data, 8'(i - 1));
                chk($sformatf("bstream%0d_y_src", i), {7'd0, y_src}, 8'd1);
                chk($sformatf("bstream%0d_y_valid", i), {7'd0, y_valid}, 8'd1);
            end
            next_cycle();
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("bstream_last_y_data", y_data, 8'h09);
        chk("bstream_last_y_src", {7'd0, y_src}, 8'd1);
        next_cycle();

        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1);
            @(negedge clk);
            if (k == 0) chk("alt_first_a_ready", {7'd0, a_ready1}, 8'd1);
            else begin
                chk($sformatf("alt%0d_y_src", k), {7'd0, y_src1}, 8'((k - 1) % 2));
                chk($sformatf("alt%0d_y_data", k), y_data1, (k % 2 == 1) ? 8'hA1 : 8'hB2);
            end
            chk($sformatf("alt%0d_one_ready", k), {7'd0, a_ready ^ b_ready}, 8'd1);
            next_cycle();
        end

        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_y_valid", {7'd0, y_valid}, 8'd0);
        chk("async_rst_y_data", y_data, 8'h00);
        chk("async_rst_y_valid_b1", {7'd0, y_valid1}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_a_ready", {7'd0, a_ready}, 8'd1);
        chk("post_rst_b_ready", {7'd0, b_ready}, 8'd0);
        chk("post_rst_sel", {7'd0, sel}, 8'd0);
        next_cycle();
        @(negedge clk);
        chk("post_rst_y_data", y_data, 8'hA1);
        chk("post_rst_y_src", {7'd0, y_src}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
